// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the M stage: word RAM below MMIO_BASE, plus an LCD transmit
// FIFO with drain FSM, a PS/2 key latch and a status register. Build with LCD_PACE_EN for GAP pacing.
module dmem_mmio_responder #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] MMIO_BASE  = 12'hFF0,
    parameter int          LCD_GAP    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    input  logic        dmem_wren,
    input  logic        dmem_rden,
    output logic [31:0] dmem_out,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_out,
    input  logic        lcd_ready,
    output logic        lcd_write,
    output logic [31:0] lcd_data
);
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;
    localparam int RAM_WORDS = int'(MMIO_BASE);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LCD_GAP < 1) begin : g_bad_params
        $error("dmem_mmio_responder: illegal FIFO_DEPTH or LCD_GAP");
    end

`ifdef LCD_PACE_EN
    localparam int GW = (LCD_GAP > 1) ? $clog2(LCD_GAP) : 1;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;
    logic [GW-1:0] gap_q, gap_d;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1} state_t;
`endif

    logic [31:0]   mem [RAM_WORDS];
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          ps2_valid_q, ps2_valid_d;
    logic [7:0]    ps2_key_q, ps2_key_d;
    logic          lcd_write_q, lcd_write_d;
    logic [31:0]   lcd_data_q, lcd_data_d;
    logic [31:0]   dmem_out_q, dmem_out_d;

    logic [11:0]   mmio_off_s;
    logic          is_ram_s, rd_op_s, ram_we_s, push_req_s, ps2_rd_s, stat_rd_s;
    logic          full_s, push_s, pop_s, ovf_set_s;

    // Address decode; a simultaneous write suppresses the read.
    always_comb begin
        is_ram_s   = (dmem_address < MMIO_BASE);
        mmio_off_s = dmem_address - MMIO_BASE;
        rd_op_s    = dmem_rden & ~dmem_wren;
        ram_we_s   = dmem_wren & is_ram_s;
        push_req_s = dmem_wren & ~is_ram_s & (mmio_off_s == 12'd0);
        ps2_rd_s   = rd_op_s & ~is_ram_s & (mmio_off_s == 12'd1);
        stat_rd_s  = rd_op_s & ~is_ram_s & (mmio_off_s == 12'd2);
    end

    // Drain FSM: pops the head when idle and the LCD is ready.
    always_comb begin
        state_d     = state_q;
        lcd_write_d = 1'b0;
        lcd_data_d  = lcd_data_q;
        pop_s       = 1'b0;
`ifdef LCD_PACE_EN
        gap_d       = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != CW'(0) && lcd_ready) begin
                    state_d     = S_SEND;
                    lcd_write_d = 1'b1;
                    lcd_data_d  = fifo_mem[rd_ptr_q];
                    pop_s       = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
`ifdef LCD_PACE_EN
                state_d = S_GAP;
                gap_d   = GW'(LCD_GAP - 1);
`else
                state_d = S_IDLE;
`endif
            end
`ifdef LCD_PACE_EN
            // Leave GAP on the edge where the counter reaches zero.
            S_GAP: begin
                if (gap_q <= GW'(1)) begin
                    state_d = S_IDLE;
                    gap_d   = GW'(0);
                end else begin
                    state_d = S_GAP;
                    gap_d   = gap_q - GW'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a pop in the same cycle frees a slot for a push into a full FIFO.
    always_comb begin
        full_s    = (count_q == CW'(FIFO_DEPTH));
        push_s    = push_req_s & (~full_s | pop_s);
        ovf_set_s = push_req_s & full_s & ~pop_s;
        wr_ptr_d  = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = (stat_rd_s ? 1'b0 : ovf_q) | ovf_set_s;
    end

    // PS/2 latch and read-data mux; a new key press wins over the read-clear.
    always_comb begin
        if (ps2_key_pressed) begin
            ps2_valid_d = 1'b1;
            ps2_key_d   = ps2_out;
        end else begin
            ps2_valid_d = ps2_rd_s ? 1'b0 : ps2_valid_q;
            ps2_key_d   = ps2_key_q;
        end
        dmem_out_d = dmem_out_q;
        if (rd_op_s) begin
            if (is_ram_s) begin
                dmem_out_d = mem[dmem_address];
            end else begin
                case (mmio_off_s)
                    12'd1:   dmem_out_d = {ps2_valid_q, 23'd0, ps2_key_q};
                    12'd2:   dmem_out_d = {ovf_q, 26'd0, 5'(count_q)};
                    default: dmem_out_d = 32'd0;
                endcase
            end
        end else begin
            dmem_out_d = dmem_out_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= PW'(0);
            rd_ptr_q    <= PW'(0);
            count_q     <= CW'(0);
            ovf_q       <= 1'b0;
            ps2_valid_q <= 1'b0;
            ps2_key_q   <= 8'd0;
            lcd_write_q <= 1'b0;
            lcd_data_q  <= 32'd0;
            dmem_out_q  <= 32'd0;
`ifdef LCD_PACE_EN
            gap_q       <= GW'(0);
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            ps2_valid_q <= ps2_valid_d;
            ps2_key_q   <= ps2_key_d;
            lcd_write_q <= lcd_write_d;
            lcd_data_q  <= lcd_data_d;
            dmem_out_q  <= dmem_out_d;
`ifdef LCD_PACE_EN
            gap_q       <= gap_d;
`endif
        end
    end

    // Storage arrays are not cleared by reset.
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            mem[dmem_address] <= dmem_data_in;
        end
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= dmem_data_in;
        end
    end

    assign dmem_out  = dmem_out_q;
    assign lcd_write = lcd_write_q;
    assign lcd_data  = lcd_data_q;
endmodule
